// File: rtl/wb_dual_master_arbiter_if.sv
// Wishbone classic bundle for the dual-master arbiter: two core-side
// masters, the Controller-side port, and the current grant.
interface wb_dual_master_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  m0_cyc_i;
   logic                  m0_stb_i;
   logic                  m0_we_i;
   logic [ADDR_WIDTH-1:0] m0_addr_i;
   logic [DATA_WIDTH-1:0] m0_data_i;
   logic [DATA_WIDTH-1:0] m0_data_o;
   logic                  m0_ack_o;
   logic                  m0_err_o;

   logic                  m1_cyc_i;
   logic                  m1_stb_i;
   logic                  m1_we_i;
   logic [ADDR_WIDTH-1:0] m1_addr_i;
   logic [DATA_WIDTH-1:0] m1_data_i;
   logic [DATA_WIDTH-1:0] m1_data_o;
   logic                  m1_ack_o;
   logic                  m1_err_o;

   logic                  s_cyc_o;
   logic                  s_stb_o;
   logic                  s_we_o;
   logic [ADDR_WIDTH-1:0] s_addr_o;
   logic [DATA_WIDTH-1:0] s_data_o;
   logic [DATA_WIDTH-1:0] s_data_i;
   logic                  s_ack_i;
   logic [1:0]            grant_o;

   modport slave (
      input  m0_cyc_i, m0_stb_i, m0_we_i, m0_addr_i, m0_data_i,
      output m0_data_o, m0_ack_o, m0_err_o,
      input  m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_data_i,
      output m1_data_o, m1_ack_o, m1_err_o,
      output s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o,
      input  s_data_i, s_ack_i,
      output grant_o
   );

   modport master (
      output m0_cyc_i, m0_stb_i, m0_we_i, m0_addr_i, m0_data_i,
      input  m0_data_o, m0_ack_o, m0_err_o,
      output m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_data_i,
      input  m1_data_o, m1_ack_o, m1_err_o,
      input  s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o,
      output s_data_i, s_ack_i,
      input  grant_o
   );
endinterface

// File: rtl/wb_dual_master_arbiter.sv
// Round-robin arbiter merging fetch (m0) and load/store (m1) Wishbone
// masters onto the Controller bus, with a per-transaction ack watchdog.
module wb_dual_master_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst_n,
   wb_dual_master_arbiter_if.slave bus
);
   localparam int CW = (TIMEOUT_CYCLES > 0) ?
                       $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic          last_grant_q, last_grant_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic req0, req1;
   logic g0, g1;
   logic stb;
   logic expire;

   assign req0 = bus.m0_cyc_i & bus.m0_stb_i;
   assign req1 = bus.m1_cyc_i & bus.m1_stb_i;
   assign g0   = (state_q == GRANT0);
   assign g1   = (state_q == GRANT1);
   assign stb  = (g0 & bus.m0_stb_i) | (g1 & bus.m1_stb_i);

   // Ack on the final cycle wins over expiry.
   assign expire = (TIMEOUT_CYCLES > 0) && stb && !bus.s_ack_i &&
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (req0 && req1)
               state_d = last_grant_q ? GRANT0 : GRANT1;
            else if (req0)
               state_d = GRANT0;
            else if (req1)
               state_d = GRANT1;
         end
         GRANT0: begin
            if (expire)
               state_d = IDLE;
            else if (!bus.m0_cyc_i)
               state_d = req1 ? GRANT1 : IDLE;
         end
         GRANT1: begin
            if (expire)
               state_d = IDLE;
            else if (!bus.m1_cyc_i)
               state_d = req0 ? GRANT0 : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      if (state_d != state_q) begin
         cnt_d = '0;
         if (state_d != IDLE)
            last_grant_d = (state_d == GRANT1);
      end else if (bus.s_ack_i || (state_q == IDLE)) begin
         cnt_d = '0;
      end else if ((TIMEOUT_CYCLES > 0) && stb) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_comb begin
      bus.s_cyc_o   = 1'b0;
      bus.s_stb_o   = 1'b0;
      bus.s_we_o    = 1'b0;
      bus.s_addr_o  = '0;
      bus.s_data_o  = '0;
      bus.m0_data_o = '0;
      bus.m0_ack_o  = 1'b0;
      bus.m0_err_o  = 1'b0;
      bus.m1_data_o = '0;
      bus.m1_ack_o  = 1'b0;
      bus.m1_err_o  = 1'b0;
      bus.grant_o   = {g1, g0};
      unique case (1'b1)
         g0: begin
            bus.s_cyc_o   = bus.m0_cyc_i;
            bus.s_stb_o   = bus.m0_stb_i;
            bus.s_we_o    = bus.m0_we_i;
            bus.s_addr_o  = bus.m0_addr_i;
            bus.s_data_o  = bus.m0_data_i;
            bus.m0_data_o = bus.s_data_i;
            bus.m0_ack_o  = bus.s_ack_i;
            bus.m0_err_o  = expire;
         end
         g1: begin
            bus.s_cyc_o   = bus.m1_cyc_i;
            bus.s_stb_o   = bus.m1_stb_i;
            bus.s_we_o    = bus.m1_we_i;
            bus.s_addr_o  = bus.m1_addr_i;
            bus.s_data_o  = bus.m1_data_i;
            bus.m1_data_o = bus.s_data_i;
            bus.m1_ack_o  = bus.s_ack_i;
            bus.m1_err_o  = expire;
         end
         default: ;
      endcase
   end
endmodule
